// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and the GF(2^8) doubling helper.
// Configuration macro AES_KEY_CACHE_EN (key replay store) is consumed by the other files.
package aes_pkg;

  typedef logic [7:0] aes_byte;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VALID  = 2'd1,
    DONE   = 2'd2,
    REPLAY = 2'd3
  } ks_state_e;

  localparam int unsigned AES_NUM_RND   = 10;
  localparam aes_byte     AES_RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic aes_byte aes_xtime(input aes_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_store.sv
// Round-key register file for replay: one write port, one combinational read port.
// Only instantiated when AES_KEY_CACHE_EN is defined.
module aes_key_store #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [127:0]  rdata
);

  logic [127:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: drives aes_key_gen and streams round keys over valid/ready.
// Define AES_KEY_CACHE_EN to add the round-key store and the replay_i port.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_RND   = AES_NUM_RND,
  parameter logic [7:0]  RCON_INIT = AES_RCON_INIT
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start_i,
  input  logic         abort_i,
`ifdef AES_KEY_CACHE_EN
  input  logic         replay_i,
`endif
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         kg_en_o,
  output logic         kg_gen_key_o,
  output logic         kg_next_rnd_o,
  output logic [7:0]   kg_rcon_o,
  input  logic [127:0] kg_key_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [3:0]   rk_idx_o,
  output logic [127:0] rk_key_o
);

  localparam int unsigned RW = $clog2(NUM_RND + 1);
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_VALID  = VALID;
  localparam logic [1:0] ST_DONE   = DONE;
  localparam logic [1:0] ST_REPLAY = REPLAY;
  localparam logic [RW-1:0] RND_LAST = RW'(NUM_RND);
  localparam logic [RW-1:0] RND_ONE  = RW'(1);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [7:0]    rcon_nxt;

  assign rcon_nxt = aes_xtime(rcon_q);

`ifdef AES_KEY_CACHE_EN
  logic         store_vld_q, store_vld_d;
  logic         st_we;
  logic [127:0] st_rdata;

  aes_key_store #(.DEPTH(NUM_RND), .AW(RW)) u_store (
    .clk   (clk),
    .we    (st_we),
    .waddr (rnd_q - RND_ONE),
    .wdata (kg_key_i),
    .raddr (rnd_q - RND_ONE),
    .rdata (st_rdata)
  );
`endif

  always_comb begin
    state_d       = state_q;
    rnd_d         = rnd_q;
    rcon_d        = rcon_q;
    ready_o       = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    kg_en_o       = 1'b0;
    kg_next_rnd_o = 1'b0;
    kg_rcon_o     = 8'h00;
    rk_valid_o    = 1'b0;
`ifdef AES_KEY_CACHE_EN
    store_vld_d   = store_vld_q;
    st_we         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i && !abort_i) begin
          kg_en_o   = 1'b1;
          kg_rcon_o = RCON_INIT;
          state_d   = ST_VALID;
          rnd_d     = RND_ONE;
          rcon_d    = RCON_INIT;
`ifdef AES_KEY_CACHE_EN
          store_vld_d = 1'b0;
        end else if (replay_i && store_vld_q && !abort_i) begin
          state_d = ST_REPLAY;
          rnd_d   = RND_ONE;
`endif
        end
      end
      ST_VALID: begin
        busy_o     = 1'b1;
        rk_valid_o = 1'b1;
        if (rk_ready_i && !abort_i) begin
`ifdef AES_KEY_CACHE_EN
          st_we = 1'b1;
`endif
          if (rnd_q < RND_LAST) begin
            // Issue the next round now so its key lands on the following cycle.
            kg_en_o       = 1'b1;
            kg_next_rnd_o = 1'b1;
            kg_rcon_o     = rcon_nxt;
            rcon_d        = rcon_nxt;
            rnd_d         = rnd_q + RND_ONE;
          end else begin
            state_d = ST_DONE;
`ifdef AES_KEY_CACHE_EN
            store_vld_d = 1'b1;
`endif
          end
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
        rnd_d   = '0;
        rcon_d  = RCON_INIT;
      end
`ifdef AES_KEY_CACHE_EN
      ST_REPLAY: begin
        busy_o     = 1'b1;
        rk_valid_o = 1'b1;
        if (rk_ready_i && !abort_i) begin
          if (rnd_q < RND_LAST) rnd_d = rnd_q + RND_ONE;
          else                  state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) begin
      state_d = ST_IDLE;
      rnd_d   = '0;
      rcon_d  = RCON_INIT;
`ifdef AES_KEY_CACHE_EN
      store_vld_d = 1'b0;
`endif
    end
  end

  assign kg_gen_key_o = kg_en_o;
  assign rk_idx_o     = rk_valid_o ? 4'(rnd_q) : 4'd0;

`ifdef AES_KEY_CACHE_EN
  assign rk_key_o = (state_q == ST_REPLAY) ? st_rdata : kg_key_i;
`else
  assign rk_key_o = kg_key_i;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
    end
  end

`ifdef AES_KEY_CACHE_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) store_vld_q <= 1'b0;
    else       store_vld_q <= store_vld_d;
  end
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural aes_key_gen plus a FIPS-197 word-array reference.
// Exercises the replay path when AES_KEY_CACHE_EN is defined.
module tb_aes_key_sched_ctrl;

  logic         clk, nrst, start_i, abort_i, rk_ready_i;
  logic         ready_o, busy_o, done_o, kg_en_o, kg_gen_key_o, kg_next_rnd_o, rk_valid_o;
  logic [7:0]   kg_rcon_o;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_key_o;
  logic [127:0] key_in;
  logic [127:0] kg_key = '0;
`ifdef AES_KEY_CACHE_EN
  logic         replay_i;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [1:10];
  logic [7:0]   exp_rc [1:11];
  logic [127:0] last_key;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  aes_key_sched_ctrl dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .abort_i(abort_i),
`ifdef AES_KEY_CACHE_EN
    .replay_i(replay_i),
`endif
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .kg_en_o(kg_en_o), .kg_gen_key_o(kg_gen_key_o), .kg_next_rnd_o(kg_next_rnd_o),
    .kg_rcon_o(kg_rcon_o), .kg_key_i(kg_key),
    .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i), .rk_idx_o(rk_idx_o), .rk_key_o(rk_key_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]], sbox_t[w[31:24]]};
  endfunction

  // Environment model of aes_key_gen: one key-schedule round per enabled cycle.
  function automatic logic [127:0] kg_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ subrot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always @(posedge clk) begin
    if (kg_en_o) kg_key <= kg_round(kg_next_rnd_o ? kg_key : key_in, kg_rcon_o);
  end

  task automatic build_sbox();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(i), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 style 44-word expansion; rcon[i] = 2^(i-1) in GF(2^8).
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int r = 1; r <= 11; r++) begin
      exp_rc[r] = rc;
      rc = gmul(rc, 8'h02);
    end
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) t = subrot(t) ^ {exp_rc[i/4], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 1; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ready"}, ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_valid"}, rk_valid_o, 0);
    chk({tag, "_en"}, {kg_en_o, kg_gen_key_o, kg_next_rnd_o}, 0);
    chk({tag, "_rcon"}, kg_rcon_o, 0);
    chk({tag, "_idx"}, rk_idx_o, 0);
  endtask

  // One expansion with optional stall / stray start / abort / reset at a given round.
  task automatic do_run(input logic [127:0] key, input int rdy_pct, input int stall_rnd,
                        input int start_rnd, input int abort_rnd, input int rst_rnd, input bit fips);
    int idx = 1;
    int stall = 0;
    bit fin = 0;
    bit rdy, ab, rs, en_exp;
    expand(key);
    @(negedge clk);
    key_in = key; start_i = 1'b1;
    #1;
    chk("st_ready", ready_o, 1);
    chk("st_en", {kg_en_o, kg_gen_key_o, kg_next_rnd_o}, 3'b110);
    chk("st_rcon", kg_rcon_o, exp_rc[1]);
    ab = 0; rs = 0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      @(negedge clk);
      start_i = (idx == start_rnd);
      rdy = ($urandom_range(99) < rdy_pct);
      if (idx == stall_rnd && stall < 3) begin rdy = 0; stall++; end
      rk_ready_i = rdy;
      ab = (idx == abort_rnd);
      abort_i = ab;
      rs = (idx == rst_rnd);
      if (rs) nrst = 1'b0;
      #1;
      if (rs) begin
        chk_idle_outs("rst_mid");
        fin = 1;
      end else if (done_o) begin
        chk("done_idx", idx, 11);
        chk("done_valid", rk_valid_o, 0);
        if (fips) chk("done_lat", cyc, 11);
        fin = 1;
      end else begin
        chk("rk_valid", {rk_valid_o, ready_o, busy_o}, 3'b101);
        chk("rk_idx", rk_idx_o, idx);
        chk("rk_key", rk_key_o, exp_rk[idx]);
        en_exp = rdy && !ab && idx < 10;
        chk("kg_en", {kg_en_o, kg_gen_key_o}, {en_exp, en_exp});
        chk("kg_rcon", kg_rcon_o, en_exp ? exp_rc[idx+1] : 8'h00);
        if (en_exp) chk("kg_nxt", kg_next_rnd_o, 1);
        if (ab) fin = 1;
        else if (rdy) begin
          if (idx == 10) last_key = rk_key_o;
          idx++;
        end
      end
    end
    chk("run_ended", fin, 1);
    @(negedge clk);
    start_i = 0; abort_i = 0; rk_ready_i = 0; nrst = 1'b1;
    #1;
    if (ab) begin
      chk("abort_ready", ready_o, 1);
      chk("abort_valid", rk_valid_o, 0);
      chk("abort_done", done_o, 0);
    end else begin
      chk("post_idle", ready_o, 1);
    end
  endtask

`ifdef AES_KEY_CACHE_EN
  task automatic do_replay();
    int idx = 1;
    bit fin = 0;
    bit rdy;
    @(negedge clk);
    replay_i = 1'b1;
    #1;
    chk("rp_entry", {ready_o, kg_en_o}, 2'b10);
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      @(negedge clk);
      replay_i = 1'b0;
      rdy = ($urandom_range(99) < 70);
      rk_ready_i = rdy;
      #1;
      chk("rp_kg_en", kg_en_o, 0);
      if (done_o) begin
        chk("rp_done_idx", idx, 11);
        fin = 1;
      end else begin
        chk("rp_idx", rk_idx_o, idx);
        chk("rp_key", rk_key_o, exp_rk[idx]);
        if (rdy) idx++;
      end
    end
    chk("rp_ended", fin, 1);
    rk_ready_i = 0;
  endtask
`endif

  initial begin
    nrst = 1'b0; start_i = 0; abort_i = 0; rk_ready_i = 0; key_in = '0; last_key = '0;
`ifdef AES_KEY_CACHE_EN
    replay_i = 0;
`endif
    build_sbox();
    #12;
    chk_idle_outs("reset");
    @(negedge clk);
    nrst = 1'b1;

    do_run(FIPS_KEY, 100, 0, 0, 0, 0, 1);
    chk("fips_rk10", last_key, FIPS_R10);
    do_run(FIPS_KEY, 100, 4, 0, 0, 0, 0);
    do_run({$urandom, $urandom, $urandom, $urandom}, 100, 0, 6, 0, 0, 0);
    do_run({$urandom, $urandom, $urandom, $urandom}, 70, 0, 0, 3, 0, 0);
    do_run(FIPS_KEY, 100, 0, 0, 0, 0, 0);
    chk("fips_after_abort", last_key, FIPS_R10);
    do_run({$urandom, $urandom, $urandom, $urandom}, 100, 0, 0, 0, 7, 0);

    // Abort and start together in IDLE: start is dropped.
    @(negedge clk);
    start_i = 1; abort_i = 1;
    #1;
    chk("ab_st_en", kg_en_o, 0);
    @(negedge clk);
    start_i = 0; abort_i = 0;
    #1;
    chk("ab_st_idle", {ready_o, busy_o}, 2'b10);

    for (int n = 0; n < 3; n++)
      do_run({$urandom, $urandom, $urandom, $urandom}, 60, 0, 0, 0, 0, 0);

`ifdef AES_KEY_CACHE_EN
    do_replay();
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1; replay_i = 1'b1;
    @(negedge clk);
    replay_i = 1'b0;
    #1;
    chk("rp_after_rst", {ready_o, rk_valid_o}, 2'b10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
